// File: rtl/game_ctrl_pkg.sv
// game_ctrl_pkg: shared types and constants for the game round controller.
package game_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, CLR, REPORT} state_t;
  typedef enum logic [1:0] {MODE_UP1 = 2'b00, MODE_UP2 = 2'b01, MODE_DN1 = 2'b10, MODE_DN2 = 2'b11} mode_t;
  localparam logic [1:0] WHO_WIN  = 2'b01;
  localparam logic [1:0] WHO_LOSE = 2'b10;
  typedef struct packed {
    mode_t      mode;
    logic [3:0] init;
  } plan_t;
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
    return (en && v != 8'hff) ? v + 8'd1 : v;
  endfunction
endpackage

// File: rtl/game_round_controller_plan_fifo.sv
// plan_fifo: DEPTH-entry round-plan queue with registered full/empty flags and no bypass.
module plan_fifo
  import game_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_push,
  input  plan_t i_data,
  input  logic  i_pop,
  output plan_t o_data,
  output logic  o_full,
  output logic  o_empty
);
  localparam int AW = $clog2(DEPTH);
  plan_t r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt, w_cnt;
  logic r_full, r_empty, w_push, w_pop;
  assign w_push  = i_push && !r_full;
  assign w_pop   = i_pop && !r_empty;
  assign w_cnt   = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign o_data  = r_mem[r_rp];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wp    <= r_wp + AW'(w_push);
      r_rp    <= r_rp + AW'(w_pop);
      r_cnt   <= w_cnt;
      r_full  <= w_cnt == (AW+1)'(DEPTH);
      r_empty <= w_cnt == '0;
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wp] <= i_data;
endmodule

// File: rtl/game_round_controller.sv
// game_round_controller: runs queued round plans on the multi-mode counter and reports results.
// Optional macro GAME_TIMEOUT_EN ends a round after MAX_RUN RUN cycles without GAMEOVER.
module game_round_controller
  import game_ctrl_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CYC_W   = 16,
  parameter int MAX_RUN = 5000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             plan_valid,
  output logic             plan_ready,
  input  logic [1:0]       plan_mode,
  input  logic [3:0]       plan_init,
  output logic [1:0]       control,
  output logic             INIT,
  output logic [3:0]       initial_value,
  output logic             cnt_reset,
  input  logic             GAMEOVER,
  input  logic [1:0]       WHO,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_who,
  output logic [CYC_W-1:0] res_cycles,
  output logic             res_err,
  output logic [7:0]       win_tally,
  output logic [7:0]       lose_tally,
  output logic             busy
);
  state_t r_state, w_next;
  plan_t w_in, w_head;
  mode_t r_ctrl;
  logic [3:0] r_ival;
  logic [CYC_W-1:0] r_cyc;
  logic [1:0] r_who;
  logic [7:0] r_win, r_lose;
  logic r_init, r_crst, r_valid, r_err, r_busy;
  logic w_full, w_empty, w_pop, w_go, w_to;
  assign w_in = '{mode: mode_t'(plan_mode), init: plan_init};
  plan_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (plan_valid),
    .i_data (w_in),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  assign w_pop = r_state == IDLE && enable && !w_empty;
  assign w_go  = r_state == RUN && GAMEOVER;
`ifdef GAME_TIMEOUT_EN
  assign w_to = r_state == RUN && !GAMEOVER && r_cyc == CYC_W'(MAX_RUN - 1);
`else
  assign w_to = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_pop ? LOAD : IDLE;
      LOAD:    w_next = RUN;
      RUN:     w_next = (w_go || w_to) ? CLR : RUN;
      CLR:     w_next = REPORT;
      REPORT:  w_next = res_ready ? IDLE : REPORT;
      default: w_next = IDLE;
    endcase
  end
  // Control outputs are decoded from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ctrl  <= MODE_UP1;
      r_ival  <= '0;
      r_init  <= 1'b0;
      r_crst  <= 1'b1;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_cyc   <= '0;
      r_who   <= '0;
      r_err   <= 1'b0;
      r_win   <= '0;
      r_lose  <= '0;
    end else begin
      r_state <= w_next;
      r_init  <= w_next == LOAD;
      r_crst  <= w_next == CLR;
      r_valid <= w_next == REPORT;
      r_busy  <= w_next != IDLE;
      if (w_pop) begin
        r_ctrl <= w_head.mode;
        r_ival <= w_head.init;
      end
      if (r_state == LOAD) r_cyc <= '0;
      else if (r_state == RUN && r_cyc != '1) r_cyc <= r_cyc + 1'b1;
      if (w_go) begin
        r_who  <= WHO;
        r_err  <= WHO[1] == WHO[0];
        r_win  <= sat_inc(r_win, WHO == WHO_WIN);
        r_lose <= sat_inc(r_lose, WHO == WHO_LOSE);
      end else if (w_to) begin
        r_who <= 2'b00;
        r_err <= 1'b1;
      end
    end
  end
  assign plan_ready    = !w_full;
  assign control       = r_ctrl;
  assign INIT          = r_init;
  assign initial_value = r_ival;
  assign cnt_reset     = r_crst;
  assign res_valid     = r_valid;
  assign res_who       = r_who;
  assign res_cycles    = r_cyc;
  assign res_err       = r_err;
  assign win_tally     = r_win;
  assign lose_tally    = r_lose;
  assign busy          = r_busy;
endmodule

// File: tb/tb_game_round_controller.sv
// tb_game_round_controller: scoreboard bench; stimulus queues expectations, monitors pop and compare.
module tb_game_round_controller;
  logic clk = 0, reset = 1, enable = 0, plan_valid = 0, res_ready = 1, GAMEOVER = 0;
  logic [1:0] plan_mode = 0, WHO = 0;
  logic [3:0] plan_init = 0;
  logic plan_ready, INIT, cnt_reset, res_valid, res_err, busy;
  logic [1:0] control, res_who;
  logic [3:0] initial_value;
  logic [15:0] res_cycles;
  logic [7:0] win_tally, lose_tally;

  game_round_controller #(.DEPTH(4), .CYC_W(16), .MAX_RUN(20)) dut (
    .clk(clk), .reset(reset), .enable(enable), .plan_valid(plan_valid), .plan_ready(plan_ready),
    .plan_mode(plan_mode), .plan_init(plan_init), .control(control), .INIT(INIT),
    .initial_value(initial_value), .cnt_reset(cnt_reset), .GAMEOVER(GAMEOVER), .WHO(WHO),
    .res_valid(res_valid), .res_ready(res_ready), .res_who(res_who), .res_cycles(res_cycles),
    .res_err(res_err), .win_tally(win_tally), .lose_tally(lose_tally), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [1:0] who; logic [15:0] cyc; logic err; logic [7:0] win; logic [7:0] lose;} res_t;
  typedef struct {logic [1:0] mode; logic [3:0] init; int n; logic [1:0] who;} rnd_t;
  res_t exp_q[$];
  rnd_t rq[$];
  rnd_t iq[$];
  int checks = 0, errors = 0;
  logic [7:0] m_win = 0, m_lose = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] m, input logic [3:0] i, input int n, input logic [1:0] w,
                      input bit want_res, input logic [15:0] cyc);
    rnd_t r;
    res_t e;
    int k = 0;
    r = '{mode: m, init: i, n: n, who: w};
    while (!plan_ready && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    if (!plan_ready) begin
      chk("push_ready_timeout", 0, 1);
      return;
    end
    rq.push_back(r);
    iq.push_back(r);
    if (want_res) begin
      if (w == 2'b01 && m_win != 8'hff) m_win++;
      if (w == 2'b10 && m_lose != 8'hff) m_lose++;
      e = '{who: w, cyc: cyc, err: (w == 2'b00 || w == 2'b11), win: m_win, lose: m_lose};
      exp_q.push_back(e);
    end
    plan_valid = 1; plan_mode = m; plan_init = i;
    @(posedge clk); #1;
    plan_valid = 0;
  endtask

  task automatic wait_init();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!INIT && k < 200);
    chk("init_seen", INIT, 1);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    exp_q.delete(); rq.delete(); iq.delete();
    m_win = 0; m_lose = 0;
  endtask

  always @(negedge clk) begin : mon
    rnd_t r;
    res_t e;
    if (!reset) begin
      if (INIT) begin
        if (iq.size() == 0) chk("init_unexpected", 1, 0);
        else begin
          r = iq.pop_front();
          chk("init_control", control, r.mode);
          chk("init_value", initial_value, r.init);
        end
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("res_who", res_who, e.who);
          chk("res_cycles", res_cycles, e.cyc);
          chk("res_err", res_err, e.err);
          chk("win_tally", win_tally, e.win);
          chk("lose_tally", lose_tally, e.lose);
        end
      end
    end
  end

  initial begin : responder
    rnd_t r;
    forever begin
      @(negedge clk);
      if (INIT && !reset) begin
        if (rq.size() == 0) chk("resp_no_round", 1, 0);
        else begin
          r = rq.pop_front();
          if (r.n > 0) begin
            repeat (r.n) @(posedge clk);
            #1 GAMEOVER = 1; WHO = r.who;
            @(posedge clk);
            #1 GAMEOVER = 0; WHO = 2'b11;
            chk("cnt_reset_after_go", cnt_reset, 1);
            @(posedge clk); #1;
            chk("res_valid_after_go", res_valid, 1);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_cnt_reset_hi", cnt_reset, 1);
    @(posedge clk); #1;
    chk("rst_cnt_reset_lo", cnt_reset, 0);
    chk("rst_control", control, 0);
    chk("rst_INIT", INIT, 0);
    chk("rst_initial_value", initial_value, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_who", res_who, 0);
    chk("rst_res_cycles", res_cycles, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_win", win_tally, 0);
    chk("rst_lose", lose_tally, 0);
    chk("rst_busy", busy, 0);
    chk("rst_plan_ready", plan_ready, 1);

    // basic round: pop next cycle, INIT one cycle, win after 40 RUN cycles
    enable = 1;
    push(2'b01, 4'd15, 40, 2'b01, 1, 16'd40);
    @(posedge clk); #1;
    chk("t2_init_pulse", INIT, 1);
    chk("t2_control", control, 2'b01);
    chk("t2_initial_value", initial_value, 4'd15);
    @(posedge clk); #1;
    chk("t2_init_low", INIT, 0);
    drain();

    // fill FIFO, then back-pressure the first result
    enable = 0;
    res_ready = 0;
    push(2'b00, 4'd1, 3, 2'b10, 1, 16'd3);
    push(2'b10, 4'd2, 5, 2'b01, 1, 16'd5);
    push(2'b11, 4'd3, 2, 2'b10, 1, 16'd2);
    push(2'b01, 4'd4, 7, 2'b01, 1, 16'd7);
    chk("t3_full", plan_ready, 0);
    enable = 1;
    push(2'b00, 4'd5, 4, 2'b10, 1, 16'd4);
    for (int k = 0; k < 200 && !res_valid; k++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("t3_stall_valid", res_valid, 1);
      chk("t3_stall_who", res_who, exp_q[0].who);
      chk("t3_stall_cycles", res_cycles, exp_q[0].cyc);
      chk("t3_stall_init", INIT, 0);
    end
    res_ready = 1;
    drain();

    // invalid WHO codes, then lose-tally saturation
    push(2'b10, 4'd9, 6, 2'b11, 1, 16'd6);
    push(2'b01, 4'd7, 2, 2'b00, 1, 16'd2);
    drain();
    for (int k = 0; k < 256; k++) push(2'b00, 4'd0, 1, 2'b10, 1, 16'd1);
    drain();
    chk("t4_lose_sat", lose_tally, 8'd255);
    chk("t4_win_kept", win_tally, 8'd3);

    // reset mid-round: no result, FIFO emptied, no resume
    push(2'b01, 4'd2, 0, 2'b00, 0, 16'd0);
    push(2'b10, 4'd3, 0, 2'b00, 0, 16'd0);
    wait_init();
    repeat (3) @(posedge clk);
    #1 chk("t5_busy_run", busy, 1);
    do_reset();
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      chk("t5_no_init", INIT, 0);
      chk("t5_no_res", res_valid, 0);
    end
    chk("t5_idle", busy, 0);
    chk("t5_ready", plan_ready, 1);
    chk("t5_win_clr", win_tally, 0);

`ifdef GAME_TIMEOUT_EN
    push(2'b11, 4'd8, 0, 2'b00, 1, 16'd20);
    wait_init();
    repeat (20) @(posedge clk);
    #1 chk("t6_no_clr_yet", cnt_reset, 0);
    @(posedge clk); #1;
    chk("t6_timeout_clr", cnt_reset, 1);
    drain();
`else
    push(2'b11, 4'd8, 0, 2'b00, 0, 16'd0);
    wait_init();
    repeat (60) @(posedge clk);
    #1;
    chk("t6_still_busy", busy, 1);
    chk("t6_no_res", res_valid, 0);
    chk("t6_no_clr", cnt_reset, 0);
    do_reset();
`endif

    chk("end_exp_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
